ahb_lite_arbiter_2m: RTL and testbench
======================================

Name: ahb_lite_arbiter_2m

Overview:
- Two-master AHB-Lite arbiter/interconnect front end. Shares the single slave-side bus (decoder, multiplexor, memory and AES128 slaves) between the RISCV32 wrapper (M0) and a second master such as a DMA/AES sequencer (M1).
- Selects the address-phase owner at transfer boundaries and never breaks bursts or locked sequences.
- Stalls the losing master through its private HREADY and routes data-phase signals to the correct master.

Parameters:
- ADDR_WIDTH, 32, address bus width
- DATA_WIDTH, 32, data bus width
- HBURST_WIDTH, 3, HBURST width
- HPROT_WIDTH, 4, HPROT width
- RR_EN, 1, 1 = round-robin arbitration, 0 = fixed priority (M0 wins)

Ports:
- HCLK  in  1  single clock
- HRESETn  in  1  reset; synchronous, active-low
- HADDR_M0/HADDR_M1  in  ADDR_WIDTH  master address
- HWRITE_M0/M1, HMASTLOCK_M0/M1  in  1 each  master control
- HSIZE_M0/M1  in  3; HBURST_M0/M1  in  HBURST_WIDTH; HPROT_M0/M1  in  HPROT_WIDTH; HTRANS_M0/M1  in  2
- HWDATA_M0/M1  in  DATA_WIDTH  master write data
- HREADY_M0/M1  out  1  per-master ready
- HRESP_M0/M1  out  1  per-master response
- HRDATA_M0/M1  out  DATA_WIDTH  read data (broadcast of HRDATA)
- HADDR, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HMASTLOCK, HWDATA  out  slave-side widths  muxed bus to decoder/slaves
- HREADY  in  1  from multiplexor
- HRESP  in  1  from multiplexor
- HRDATA  in  DATA_WIDTH  from multiplexor
- HMASTER  out  1  current address-phase owner

Behaviour:
- Request from master m = HTRANS_Mm[1] (NONSEQ or SEQ).
- State registers:
  - addr_owner (HMASTER)
  - data_valid, data_owner
  - last_grant (round-robin pointer)
- Arbitration happens only in cycles with HREADY=1. If HREADY=0, addr_owner holds.
- Hold conditions (owner kept regardless of the other request), evaluated in a HREADY=1 cycle:
  - current owner HMASTLOCK_Mx=1 with HTRANS≠IDLE; or
  - current owner HTRANS is SEQ or BUSY; or
  - the lock flag is still set (see below).
- Lock flag: set when a locked transfer is accepted; cleared on the first accepted IDLE/NONSEQ with HMASTLOCK=0 from the owner.
- Otherwise the owner is recomputed combinationally for this cycle:
  - both requesting: RR_EN=1 picks !last_grant; RR_EN=0 picks M0
  - one requesting: that master
  - none: park on the current owner
- last_grant updates to the owner when a NONSEQ from that owner is accepted (HREADY=1).
- Slave-side address/control = the owner's inputs, combinational mux. HTRANS is forced to 2'b00 while HRESETn=0.
- Data phase: on HREADY=1, data_valid ← owner HTRANS[1] and data_owner ← owner.
  - HWDATA = HWDATA of data_owner.
  - HRESP_Mm = HRESP if data_valid and data_owner=m, else 0.
- HREADY_Mm:
  - = HREADY if data_valid and data_owner=m;
  - else 0 if m requesting and m≠owner (master holds its address phase);
  - else HREADY if m=owner;
  - else 1.
- Ownership switch costs zero idle cycles. The new owner's NONSEQ is issued in the same cycle the previous owner's last address phase completes.
- ERROR response (two-cycle): the data owner is preserved across both cycles. Arbitration in the second cycle is unaffected.
- Reset (synchronous, HRESETn=0 at posedge):
  - addr_owner=0, last_grant=1, data_valid=0, lock=0
  - HREADY_M0/M1=1, HRESP_M0/M1=0, HMASTER=0
- Reset mid-transfer abandons all phases. No state survives.

Optional Feature:
- Macro AHB_ARB_STARVE_LIMIT_EN.
- With the macro defined:
  - an 8-bit wait counter per master increments each cycle that master requests and is stalled by arbitration;
  - it clears on grant;
  - when a counter reaches 255, that master wins the next arbitration point, overriding the burst hold but not the lock hold;
  - extra outputs STARVE_M0/STARVE_M1 (1 bit each) pulse for one cycle when this override fires.
- Without the macro: no counters, no extra ports, and arbitration is exactly as above.

Test Plan:
- Reset, then M0 NONSEQ write 0x0000_0010 / data 0xDEADBEEF, M1 idle -> slave sees HADDR=0x10 in cycle 1; HWDATA=0xDEADBEEF in cycle 2; HREADY_M1=1 throughout.
- Both NONSEQ in the same cycle, RR_EN=1 -> M0 granted first; M1 stalled (HREADY_M1=0) one cycle, then granted. With RR_EN=0 and repeated contention, M0 always wins.
- M1 INCR4 burst at 0x4000_0000, M0 requests at beat 2 -> all 4 beats complete on M1 (HTRANS SEQ unbroken); M0's NONSEQ appears on the bus the cycle after the last beat's address phase.
- M0 locked read-modify-write (HMASTLOCK=1) while M1 requests -> M1 held until M0 issues the unlocked IDLE; HMASTER stays 0 throughout.
- Slave inserts 3 wait states on an M1 read returning 0x12345678 -> HREADY_M1 low for 3 cycles; HRDATA_M1 sampled =0x12345678; HREADY_M0 unaffected when M0 is idle. ERROR response -> HRESP_M1=1 for 2 cycles; HRESP_M0=0.
- HRESETn low during an M1 burst data phase -> next cycle HTRANS=IDLE, HMASTER=0, HREADY_M0/M1=1. With AHB_ARB_STARVE_LIMIT_EN, M1 stalled 255 cycles behind continuous M0 bursts -> STARVE_M1 pulses and M1 is granted.

Source files
------------

// File: rtl/ahb_lite_arbiter_2m.sv
// Two-master AHB-Lite arbiter: muxes M0/M1 onto one slave bus, holds ownership across bursts/locks.
// Optional macro AHB_ARB_STARVE_LIMIT_EN adds per-master wait counters and STARVE_M0/STARVE_M1 outputs.
module ahb_lite_arbiter_2m #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int HBURST_WIDTH = 3,
  parameter int HPROT_WIDTH  = 4,
  parameter int RR_EN        = 1
) (
  input  logic                    HCLK,
  input  logic                    HRESETn,
  input  logic [ADDR_WIDTH-1:0]   HADDR_M0,
  input  logic                    HWRITE_M0,
  input  logic                    HMASTLOCK_M0,
  input  logic [2:0]              HSIZE_M0,
  input  logic [HBURST_WIDTH-1:0] HBURST_M0,
  input  logic [HPROT_WIDTH-1:0]  HPROT_M0,
  input  logic [1:0]              HTRANS_M0,
  input  logic [DATA_WIDTH-1:0]   HWDATA_M0,
  output logic                    HREADY_M0,
  output logic                    HRESP_M0,
  output logic [DATA_WIDTH-1:0]   HRDATA_M0,
  input  logic [ADDR_WIDTH-1:0]   HADDR_M1,
  input  logic                    HWRITE_M1,
  input  logic                    HMASTLOCK_M1,
  input  logic [2:0]              HSIZE_M1,
  input  logic [HBURST_WIDTH-1:0] HBURST_M1,
  input  logic [HPROT_WIDTH-1:0]  HPROT_M1,
  input  logic [1:0]              HTRANS_M1,
  input  logic [DATA_WIDTH-1:0]   HWDATA_M1,
  output logic                    HREADY_M1,
  output logic                    HRESP_M1,
  output logic [DATA_WIDTH-1:0]   HRDATA_M1,
  output logic [ADDR_WIDTH-1:0]   HADDR,
  output logic                    HWRITE,
  output logic [2:0]              HSIZE,
  output logic [HBURST_WIDTH-1:0] HBURST,
  output logic [HPROT_WIDTH-1:0]  HPROT,
  output logic [1:0]              HTRANS,
  output logic                    HMASTLOCK,
  output logic [DATA_WIDTH-1:0]   HWDATA,
  input  logic                    HREADY,
  input  logic                    HRESP,
  input  logic [DATA_WIDTH-1:0]   HRDATA,
  output logic                    HMASTER
`ifdef AHB_ARB_STARVE_LIMIT_EN
  ,
  output logic                    STARVE_M0,
  output logic                    STARVE_M1
`endif
);

  localparam logic [1:0] IDLE = 2'b00, BUSY = 2'b01, NONSEQ = 2'b10, SEQ = 2'b11;

  logic owner_q, owner_d, last_grant_q, last_grant_d;
  logic dvalid_q, dvalid_d, downer_q, downer_d, lock_q, lock_d;
  logic req0, req1, owner, pick, lock_hold, burst_hold;
  logic [1:0] q_trans, a_trans;
  logic q_lock, a_lock;

  // Requests are ignored while in reset so nobody is stalled by a master that is not yet reset.
  assign req0 = HRESETn & HTRANS_M0[1];
  assign req1 = HRESETn & HTRANS_M1[1];

  assign q_trans    = owner_q ? HTRANS_M1 : HTRANS_M0;
  assign q_lock     = owner_q ? HMASTLOCK_M1 : HMASTLOCK_M0;
  assign lock_hold  = lock_q | (q_lock & (q_trans != IDLE));
  assign burst_hold = (q_trans == SEQ) | (q_trans == BUSY);

  always_comb begin
    pick = owner_q;
    if (req0 && req1)  pick = (RR_EN != 0) ? ~last_grant_q : 1'b0;
    else if (req0)     pick = 1'b0;
    else if (req1)     pick = 1'b1;
  end

`ifdef AHB_ARB_STARVE_LIMIT_EN
  logic [7:0] wcnt0_q, wcnt0_d, wcnt1_q, wcnt1_d;
  logic starve0, starve1;
  // Only the non-owner can be starving, so at most one override fires per cycle.
  assign starve0 = HREADY & HRESETn & ~lock_hold & req0 &  owner_q & (wcnt0_q == 8'hFF);
  assign starve1 = HREADY & HRESETn & ~lock_hold & req1 & ~owner_q & (wcnt1_q == 8'hFF);
  assign STARVE_M0 = starve0;
  assign STARVE_M1 = starve1;
`endif

  always_comb begin
    owner = owner_q;
    if (HREADY && HRESETn && !lock_hold) begin
`ifdef AHB_ARB_STARVE_LIMIT_EN
      if (starve0)          owner = 1'b0;
      else if (starve1)     owner = 1'b1;
      else if (!burst_hold) owner = pick;
`else
      if (!burst_hold) owner = pick;
`endif
    end
  end

  assign a_trans   = owner ? HTRANS_M1 : HTRANS_M0;
  assign a_lock    = owner ? HMASTLOCK_M1 : HMASTLOCK_M0;
  assign HADDR     = owner ? HADDR_M1 : HADDR_M0;
  assign HWRITE    = owner ? HWRITE_M1 : HWRITE_M0;
  assign HSIZE     = owner ? HSIZE_M1 : HSIZE_M0;
  assign HBURST    = owner ? HBURST_M1 : HBURST_M0;
  assign HPROT     = owner ? HPROT_M1 : HPROT_M0;
  assign HMASTLOCK = a_lock;
  assign HTRANS    = HRESETn ? a_trans : IDLE;
  assign HMASTER   = owner;

  assign HWDATA    = downer_q ? HWDATA_M1 : HWDATA_M0;
  assign HRDATA_M0 = HRDATA;
  assign HRDATA_M1 = HRDATA;
  assign HRESP_M0  = dvalid_q & ~downer_q & HRESP;
  assign HRESP_M1  = dvalid_q &  downer_q & HRESP;

  always_comb begin
    HREADY_M0 = 1'b1;
    if (dvalid_q && !downer_q)  HREADY_M0 = HREADY;
    else if (req0 && owner)     HREADY_M0 = 1'b0;
    else if (!owner)            HREADY_M0 = HREADY;
  end

  always_comb begin
    HREADY_M1 = 1'b1;
    if (dvalid_q && downer_q)   HREADY_M1 = HREADY;
    else if (req1 && !owner)    HREADY_M1 = 1'b0;
    else if (owner)             HREADY_M1 = HREADY;
  end

  always_comb begin
    owner_d      = owner;
    last_grant_d = last_grant_q;
    dvalid_d     = dvalid_q;
    downer_d     = downer_q;
    lock_d       = lock_q;
    if (HREADY) begin
      dvalid_d = a_trans[1];
      downer_d = owner;
      if (a_trans == NONSEQ) last_grant_d = owner;
      if (a_trans[1] && a_lock)                               lock_d = 1'b1;
      else if (((a_trans == IDLE) || (a_trans == NONSEQ)) && !a_lock) lock_d = 1'b0;
    end
  end

`ifdef AHB_ARB_STARVE_LIMIT_EN
  always_comb begin
    wcnt0_d = wcnt0_q;
    wcnt1_d = wcnt1_q;
    if (!owner)                          wcnt0_d = 8'd0;
    else if (req0 && wcnt0_q != 8'hFF)   wcnt0_d = wcnt0_q + 8'd1;
    if (owner)                           wcnt1_d = 8'd0;
    else if (req1 && wcnt1_q != 8'hFF)   wcnt1_d = wcnt1_q + 8'd1;
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      wcnt0_q <= 8'd0;
      wcnt1_q <= 8'd0;
    end else begin
      wcnt0_q <= wcnt0_d;
      wcnt1_q <= wcnt1_d;
    end
  end
`endif

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      dvalid_q     <= 1'b0;
      downer_q     <= 1'b0;
      lock_q       <= 1'b0;
    end else begin
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      dvalid_q     <= dvalid_d;
      downer_q     <= downer_d;
      lock_q       <= lock_d;
    end
  end

endmodule

// File: tb/tb_ahb_lite_arbiter_2m.sv
// Directed bench for ahb_lite_arbiter_2m: a round-robin instance plus a fixed-priority instance on shared inputs.
module tb_ahb_lite_arbiter_2m;
  localparam logic [1:0] IDLE = 2'b00, NONSEQ = 2'b10, SEQ = 2'b11;

  logic        HCLK, HRESETn;
  logic [31:0] HADDR_M0, HADDR_M1, HWDATA_M0, HWDATA_M1, HRDATA;
  logic        HWRITE_M0, HWRITE_M1, HMASTLOCK_M0, HMASTLOCK_M1;
  logic [2:0]  HSIZE_M0, HSIZE_M1, HBURST_M0, HBURST_M1;
  logic [3:0]  HPROT_M0, HPROT_M1;
  logic [1:0]  HTRANS_M0, HTRANS_M1;
  logic        HREADY, HRESP;

  logic        HREADY_M0, HREADY_M1, HRESP_M0, HRESP_M1, HWRITE, HMASTLOCK, HMASTER;
  logic [31:0] HRDATA_M0, HRDATA_M1, HADDR, HWDATA;
  logic [2:0]  HSIZE, HBURST;
  logic [3:0]  HPROT;
  logic [1:0]  HTRANS;

  logic        fp_HREADY_M0, fp_HREADY_M1, fp_HRESP_M0, fp_HRESP_M1, fp_HWRITE, fp_HMASTLOCK, fp_HMASTER;
  logic [31:0] fp_HRDATA_M0, fp_HRDATA_M1, fp_HADDR, fp_HWDATA;
  logic [2:0]  fp_HSIZE, fp_HBURST;
  logic [3:0]  fp_HPROT;
  logic [1:0]  fp_HTRANS;
`ifdef AHB_ARB_STARVE_LIMIT_EN
  logic STARVE_M0, STARVE_M1, fp_STARVE_M0, fp_STARVE_M1;
`endif

  int checks = 0;
  int failures = 0;

  ahb_lite_arbiter_2m #(.RR_EN(1)) u_rr (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .HADDR_M0(HADDR_M0), .HWRITE_M0(HWRITE_M0), .HMASTLOCK_M0(HMASTLOCK_M0), .HSIZE_M0(HSIZE_M0),
    .HBURST_M0(HBURST_M0), .HPROT_M0(HPROT_M0), .HTRANS_M0(HTRANS_M0), .HWDATA_M0(HWDATA_M0),
    .HREADY_M0(HREADY_M0), .HRESP_M0(HRESP_M0), .HRDATA_M0(HRDATA_M0),
    .HADDR_M1(HADDR_M1), .HWRITE_M1(HWRITE_M1), .HMASTLOCK_M1(HMASTLOCK_M1), .HSIZE_M1(HSIZE_M1),
    .HBURST_M1(HBURST_M1), .HPROT_M1(HPROT_M1), .HTRANS_M1(HTRANS_M1), .HWDATA_M1(HWDATA_M1),
    .HREADY_M1(HREADY_M1), .HRESP_M1(HRESP_M1), .HRDATA_M1(HRDATA_M1),
    .HADDR(HADDR), .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT), .HTRANS(HTRANS),
    .HMASTLOCK(HMASTLOCK), .HWDATA(HWDATA), .HREADY(HREADY), .HRESP(HRESP), .HRDATA(HRDATA),
    .HMASTER(HMASTER)
`ifdef AHB_ARB_STARVE_LIMIT_EN
    , .STARVE_M0(STARVE_M0), .STARVE_M1(STARVE_M1)
`endif
  );

  ahb_lite_arbiter_2m #(.RR_EN(0)) u_fp (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .HADDR_M0(HADDR_M0), .HWRITE_M0(HWRITE_M0), .HMASTLOCK_M0(HMASTLOCK_M0), .HSIZE_M0(HSIZE_M0),
    .HBURST_M0(HBURST_M0), .HPROT_M0(HPROT_M0), .HTRANS_M0(HTRANS_M0), .HWDATA_M0(HWDATA_M0),
    .HREADY_M0(fp_HREADY_M0), .HRESP_M0(fp_HRESP_M0), .HRDATA_M0(fp_HRDATA_M0),
    .HADDR_M1(HADDR_M1), .HWRITE_M1(HWRITE_M1), .HMASTLOCK_M1(HMASTLOCK_M1), .HSIZE_M1(HSIZE_M1),
    .HBURST_M1(HBURST_M1), .HPROT_M1(HPROT_M1), .HTRANS_M1(HTRANS_M1), .HWDATA_M1(HWDATA_M1),
    .HREADY_M1(fp_HREADY_M1), .HRESP_M1(fp_HRESP_M1), .HRDATA_M1(fp_HRDATA_M1),
    .HADDR(fp_HADDR), .HWRITE(fp_HWRITE), .HSIZE(fp_HSIZE), .HBURST(fp_HBURST), .HPROT(fp_HPROT),
    .HTRANS(fp_HTRANS), .HMASTLOCK(fp_HMASTLOCK), .HWDATA(fp_HWDATA), .HREADY(HREADY), .HRESP(HRESP),
    .HRDATA(HRDATA), .HMASTER(fp_HMASTER)
`ifdef AHB_ARB_STARVE_LIMIT_EN
    , .STARVE_M0(fp_STARVE_M0), .STARVE_M1(fp_STARVE_M1)
`endif
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  task automatic tick();
    @(posedge HCLK); #1;
  endtask

  task automatic set_idle();
    HADDR_M0 = '0; HADDR_M1 = '0; HWDATA_M0 = '0; HWDATA_M1 = '0;
    HWRITE_M0 = 0; HWRITE_M1 = 0; HMASTLOCK_M0 = 0; HMASTLOCK_M1 = 0;
    HSIZE_M0 = 3'd2; HSIZE_M1 = 3'd2; HBURST_M0 = '0; HBURST_M1 = '0;
    HPROT_M0 = 4'h3; HPROT_M1 = 4'h3; HTRANS_M0 = IDLE; HTRANS_M1 = IDLE;
    HREADY = 1; HRESP = 0; HRDATA = '0;
  endtask

  task automatic do_reset();
    set_idle(); HRESETn = 0; tick(); tick(); HRESETn = 1;
  endtask

  task automatic test_reset();
    set_idle(); HRESETn = 0; HTRANS_M1 = NONSEQ; HRESP = 1;
    tick(); tick(); #2;
    checks++; if ({HMASTER, fp_HMASTER} !== 2'b00) begin failures++; $display("FAIL rst_hmaster got=%b exp=00", {HMASTER, fp_HMASTER}); end
    checks++; if (HTRANS !== IDLE) begin failures++; $display("FAIL rst_htrans got=%b exp=00", HTRANS); end
    checks++; if ({HREADY_M0, HREADY_M1, HRESP_M0, HRESP_M1} !== 4'b1100) begin failures++;
      $display("FAIL rst_rdy_resp got=%b exp=1100", {HREADY_M0, HREADY_M1, HRESP_M0, HRESP_M1}); end
    tick();
  endtask

  task automatic test_single_write();
    do_reset();
    HTRANS_M0 = NONSEQ; HADDR_M0 = 32'h10; HWRITE_M0 = 1; #2;
    checks++; if ({HADDR, HTRANS, HWRITE, HMASTER} !== {32'h10, NONSEQ, 1'b1, 1'b0}) begin failures++;
      $display("FAIL wr_addr got=%h/%b/%b/%b exp=10/10/1/0", HADDR, HTRANS, HWRITE, HMASTER); end
    checks++; if ({HREADY_M0, HREADY_M1} !== 2'b11) begin failures++; $display("FAIL wr_rdy_a got=%b exp=11", {HREADY_M0, HREADY_M1}); end
    tick();
    HTRANS_M0 = IDLE; HWDATA_M0 = 32'hDEADBEEF; HWDATA_M1 = 32'h11111111; #2;
    checks++; if (HWDATA !== 32'hDEADBEEF) begin failures++; $display("FAIL wr_data got=%h exp=deadbeef", HWDATA); end
    checks++; if ({HREADY_M0, HREADY_M1} !== 2'b11) begin failures++; $display("FAIL wr_rdy_d got=%b exp=11", {HREADY_M0, HREADY_M1}); end
    tick(); set_idle();
  endtask

  task automatic test_contention();
    do_reset();
    HTRANS_M0 = NONSEQ; HADDR_M0 = 32'h100; HTRANS_M1 = NONSEQ; HADDR_M1 = 32'h200; #2;
    checks++; if ({HMASTER, HADDR, HREADY_M0, HREADY_M1, fp_HMASTER} !== {1'b0, 32'h100, 1'b1, 1'b0, 1'b0}) begin failures++;
      $display("FAIL cont_c1 got=%b/%h/%b%b/%b exp=0/100/10/0", HMASTER, HADDR, HREADY_M0, HREADY_M1, fp_HMASTER); end
    tick();
    HTRANS_M0 = IDLE; #2;
    checks++; if ({HMASTER, HADDR, HREADY_M0, HREADY_M1} !== {1'b1, 32'h200, 1'b1, 1'b1}) begin failures++;
      $display("FAIL cont_c2 got=%b/%h/%b%b exp=1/200/11", HMASTER, HADDR, HREADY_M0, HREADY_M1); end
    tick();
    HTRANS_M1 = IDLE; tick();
    // Continuous contention: round-robin alternates, fixed priority keeps M0.
    HTRANS_M0 = NONSEQ; HTRANS_M1 = NONSEQ; #2;
    checks++; if ({HMASTER, fp_HMASTER} !== 2'b00) begin failures++; $display("FAIL cont_rr_a got=%b exp=00", {HMASTER, fp_HMASTER}); end
    tick(); #2;
    checks++; if ({HMASTER, fp_HMASTER} !== 2'b10) begin failures++; $display("FAIL cont_rr_b got=%b exp=10", {HMASTER, fp_HMASTER}); end
    tick(); #2;
    checks++; if ({HMASTER, fp_HMASTER} !== 2'b00) begin failures++; $display("FAIL cont_rr_c got=%b exp=00", {HMASTER, fp_HMASTER}); end
    tick(); set_idle(); tick();
  endtask

  task automatic test_burst();
    do_reset();
    HTRANS_M1 = NONSEQ; HBURST_M1 = 3'b011; HADDR_M1 = 32'h4000_0000; #2;
    checks++; if ({HMASTER, HTRANS, HADDR} !== {1'b1, NONSEQ, 32'h4000_0000}) begin failures++;
      $display("FAIL burst_b1 got=%b/%b/%h exp=1/10/40000000", HMASTER, HTRANS, HADDR); end
    tick();
    HTRANS_M0 = NONSEQ; HADDR_M0 = 32'h80;
    for (int b = 1; b < 4; b++) begin
      HTRANS_M1 = SEQ; HADDR_M1 = 32'h4000_0000 + 32'(4 * b); #2;
      checks++; if ({HMASTER, HTRANS, HADDR, HREADY_M0} !== {1'b1, SEQ, 32'h4000_0000 + 32'(4 * b), 1'b0}) begin failures++;
        $display("FAIL burst_seq%0d got=%b/%b/%h/%b exp=1/11/%h/0", b, HMASTER, HTRANS, HADDR, HREADY_M0, 32'h4000_0000 + 32'(4 * b)); end
      tick();
    end
    HTRANS_M1 = IDLE; #2;
    checks++; if ({HMASTER, HTRANS, HADDR, HREADY_M0, HREADY_M1} !== {1'b0, NONSEQ, 32'h80, 1'b1, 1'b1}) begin failures++;
      $display("FAIL burst_sw got=%b/%b/%h/%b%b exp=0/10/80/11", HMASTER, HTRANS, HADDR, HREADY_M0, HREADY_M1); end
    tick(); set_idle(); tick();
  endtask

  task automatic test_lock();
    do_reset();
    HTRANS_M0 = NONSEQ; HMASTLOCK_M0 = 1; HADDR_M0 = 32'h20; HTRANS_M1 = NONSEQ; HADDR_M1 = 32'h30; #2;
    checks++; if ({HMASTER, HREADY_M1, HMASTLOCK} !== 3'b001) begin failures++; $display("FAIL lock_rd got=%b exp=001", {HMASTER, HREADY_M1, HMASTLOCK}); end
    tick();
    HWRITE_M0 = 1; #2;
    checks++; if ({HMASTER, HREADY_M1} !== 2'b00) begin failures++; $display("FAIL lock_wr got=%b exp=00", {HMASTER, HREADY_M1}); end
    tick();
    HTRANS_M0 = IDLE; HMASTLOCK_M0 = 0; HWRITE_M0 = 0; #2;
    checks++; if ({HMASTER, HREADY_M1} !== 2'b00) begin failures++; $display("FAIL lock_idle got=%b exp=00", {HMASTER, HREADY_M1}); end
    tick(); #2;
    checks++; if ({HMASTER, HADDR} !== {1'b1, 32'h30}) begin failures++; $display("FAIL lock_rel got=%b/%h exp=1/30", HMASTER, HADDR); end
    tick(); set_idle(); tick();
  endtask

  task automatic test_wait_err();
    do_reset();
    HTRANS_M1 = NONSEQ; HADDR_M1 = 32'h50; tick();
    HTRANS_M1 = IDLE; HREADY = 0;
    for (int w = 0; w < 3; w++) begin
      #2;
      checks++; if ({HREADY_M1, HREADY_M0} !== 2'b01) begin failures++; $display("FAIL wait_%0d got=%b exp=01", w, {HREADY_M1, HREADY_M0}); end
      tick();
    end
    HREADY = 1; HRDATA = 32'h12345678; #2;
    checks++; if ({HREADY_M1, HRDATA_M1} !== {1'b1, 32'h12345678}) begin failures++;
      $display("FAIL wait_done got=%b/%h exp=1/12345678", HREADY_M1, HRDATA_M1); end
    tick();
    HTRANS_M1 = NONSEQ; HWRITE_M1 = 1; HADDR_M1 = 32'h54; tick();
    HTRANS_M1 = IDLE; HREADY = 0; HRESP = 1; #2;
    checks++; if ({HRESP_M1, HRESP_M0, HREADY_M1} !== 3'b100) begin failures++; $display("FAIL err_c1 got=%b exp=100", {HRESP_M1, HRESP_M0, HREADY_M1}); end
    tick();
    HREADY = 1; HTRANS_M0 = NONSEQ; HADDR_M0 = 32'h60; #2;
    checks++; if ({HRESP_M1, HRESP_M0, HREADY_M1, HMASTER, HREADY_M0} !== 5'b10101) begin failures++;
      $display("FAIL err_c2 got=%b exp=10101", {HRESP_M1, HRESP_M0, HREADY_M1, HMASTER, HREADY_M0}); end
    tick(); set_idle(); tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    HTRANS_M1 = NONSEQ; HBURST_M1 = 3'b011; HADDR_M1 = 32'h4000_0000; tick();
    HTRANS_M1 = SEQ; HADDR_M1 = 32'h4000_0004; tick();
    HADDR_M1 = 32'h4000_0008; HRESETn = 0; #2;
    checks++; if (HTRANS !== IDLE) begin failures++; $display("FAIL rmid_force got=%b exp=00", HTRANS); end
    tick(); #2;
    checks++; if ({HTRANS, HMASTER, HREADY_M0, HREADY_M1} !== {IDLE, 3'b011}) begin failures++;
      $display("FAIL rmid_held got=%b/%b/%b%b exp=00/0/11", HTRANS, HMASTER, HREADY_M0, HREADY_M1); end
    tick();
    HRESETn = 1; HTRANS_M1 = IDLE; #2;
    checks++; if ({HTRANS, HMASTER, HREADY_M0, HREADY_M1} !== {IDLE, 3'b011}) begin failures++;
      $display("FAIL rmid_rel got=%b/%b/%b%b exp=00/0/11", HTRANS, HMASTER, HREADY_M0, HREADY_M1); end
    tick(); set_idle(); tick();
  endtask

`ifdef AHB_ARB_STARVE_LIMIT_EN
  task automatic test_starve();
    int hit;
    logic mst;
    hit = 0; mst = 0;
    do_reset();
    HTRANS_M0 = NONSEQ; HBURST_M0 = 3'b001; HTRANS_M1 = NONSEQ; HADDR_M1 = 32'h70;
    for (int c = 1; c <= 400 && hit == 0; c++) begin
      #2;
      if (STARVE_M1) begin hit = c; mst = HMASTER; end
      tick();
      HTRANS_M0 = SEQ;
    end
    checks++; if (hit !== 256) begin failures++; $display("FAIL starve_cycle got=%0d exp=256", hit); end
    checks++; if (mst !== 1'b1) begin failures++; $display("FAIL starve_grant got=%b exp=1", mst); end
    #2;
    checks++; if (STARVE_M1 !== 1'b0) begin failures++; $display("FAIL starve_pulse got=%b exp=0", STARVE_M1); end
    tick(); set_idle(); tick();
  endtask
`endif

  initial begin
    set_idle(); HRESETn = 0;
    test_reset();
    test_single_write();
    test_contention();
    test_burst();
    test_lock();
    test_wait_err();
    test_reset_mid();
`ifdef AHB_ARB_STARVE_LIMIT_EN
    test_starve();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
